// File: rtl/telemetry_pkg.sv
// Shared register map, bit indices and FSM state type for the telemetry snapshot reader.
package telemetry_pkg;

  localparam int unsigned REG_W = 32;

  // Register word indices, i.e. req_addr[5:2]
  localparam logic [3:0] REG_CTRL     = 4'h0;  // 0x00
  localparam logic [3:0] REG_STATUS   = 4'h1;  // 0x04
  localparam logic [3:0] REG_PERIOD   = 4'h2;  // 0x08
  localparam logic [3:0] REG_MCYC_LO  = 4'h4;  // 0x10
  localparam logic [3:0] REG_MCYC_HI  = 4'h5;  // 0x14
  localparam logic [3:0] REG_MINST_LO = 4'h6;  // 0x18
  localparam logic [3:0] REG_MINST_HI = 4'h7;  // 0x1C
  localparam logic [3:0] REG_STALL_LO = 4'h8;  // 0x20
  localparam logic [3:0] REG_STALL_HI = 4'h9;  // 0x24

  localparam int unsigned CTRL_SNAP   = 0;
  localparam int unsigned CTRL_AUTO   = 1;
  localparam int unsigned CTRL_PER_EN = 2;
  localparam int unsigned CTRL_IRQ_EN = 3;

  localparam int unsigned STAT_SNAP_VALID = 0;
  localparam int unsigned STAT_OVERRUN    = 1;

  typedef enum logic {RD_IDLE, RD_RESP} telem_rd_state_t;

endpackage

// File: rtl/telemetry_period_timer.sv
// Free-running period timer: counts 0..period-1 and ticks on the last count.
module telemetry_period_timer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [31:0] period,
  input  logic        restart,
  output logic        tick
);

  logic [31:0] count;
  logic        running;

  assign running = en && (period != 32'd0);
  assign tick    = running && (count == (period - 32'd1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 32'd0;
    end else if (!running || restart || tick) begin
      count <= 32'd0;
    end else begin
      count <= count + 32'd1;
    end
  end

endmodule

// File: rtl/telemetry_snapshot_reader.sv
// MMIO reader for core telemetry counters: one-cycle coherent shadow capture, exposed as
// 32-bit lo/hi words over a single-outstanding valid/ready port, with periodic auto-snapshot.
module telemetry_snapshot_reader
  import telemetry_pkg::*;
#(
  parameter int unsigned WIDTH  = 64,
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WIDTH-1:0]  mcycle,
  input  logic [WIDTH-1:0]  minstret,
  input  logic [WIDTH-1:0]  stall_cycles,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_we,
  input  logic [REG_W-1:0]  req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [REG_W-1:0]  rsp_rdata,
  output logic              rsp_err,
  output logic              irq
);

  localparam int unsigned HI_W = WIDTH - 32;

  telem_rd_state_t  state;
  logic             auto_q, per_en_q, irq_en_q;
  logic             snap_valid_q, overrun_q;
  logic [31:0]      period_q;
  logic [WIDTH-1:0] mcyc_q, minst_q, stall_q;

  logic             accept, addr_ok, mapped, err, wr, rd;
  logic             wr_ctrl, wr_status, wr_period;
  logic [3:0]       idx;
  logic             tick, capture, clr_valid;
  logic             snap_valid_d, overrun_d;
  logic [WIDTH-1:0] mcyc_d, minst_d, stall_d;
  logic [31:0]      rd_word;

  assign accept  = req_valid && req_ready;
  assign idx     = req_addr[5:2];
  assign addr_ok = (req_addr[1:0] == 2'b00) && (req_addr[ADDR_W-1:6] == '0);

  // Address decode
  always_comb begin
    mapped = 1'b0;
    case (idx)
      REG_CTRL, REG_STATUS, REG_PERIOD,
      REG_MCYC_LO, REG_MCYC_HI, REG_MINST_LO,
      REG_MINST_HI, REG_STALL_LO, REG_STALL_HI: mapped = 1'b1;
      default:                                  mapped = 1'b0;
    endcase
  end

  assign err       = !(addr_ok && mapped);
  assign wr        = accept && req_we && !err;
  assign rd        = accept && !req_we && !err;
  assign wr_ctrl   = wr && (idx == REG_CTRL);
  assign wr_status = wr && (idx == REG_STATUS);
  assign wr_period = wr && (idx == REG_PERIOD);

  telemetry_period_timer u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (per_en_q),
    .period  (period_q),
    .restart (wr_period),
    .tick    (tick)
  );

  // Capture/consume arbitration; hardware set always beats a clear on the same edge
  always_comb begin
    capture   = tick
             || (wr_ctrl && req_wdata[CTRL_SNAP])
             || (rd && (idx == REG_MCYC_LO) && auto_q);
    clr_valid = (rd && (idx == REG_STALL_HI))
             || (wr_status && req_wdata[STAT_SNAP_VALID]);

    snap_valid_d = snap_valid_q;
    if (capture)        snap_valid_d = 1'b1;
    else if (clr_valid) snap_valid_d = 1'b0;

    overrun_d = overrun_q;
    if (tick && snap_valid_q && !clr_valid)          overrun_d = 1'b1;
    else if (wr_status && req_wdata[STAT_OVERRUN])   overrun_d = 1'b0;

    mcyc_d  = capture ? mcycle       : mcyc_q;
    minst_d = capture ? minstret     : minst_q;
    stall_d = capture ? stall_cycles : stall_q;
  end

  // Read data reflects state as committed at the accept edge, so a same-edge capture is visible
  always_comb begin
    rd_word = '0;
    case (idx)
      REG_CTRL: begin
        rd_word[CTRL_AUTO]   = auto_q;
        rd_word[CTRL_PER_EN] = per_en_q;
        rd_word[CTRL_IRQ_EN] = irq_en_q;
      end
      REG_STATUS: begin
        rd_word[STAT_SNAP_VALID] = snap_valid_d;
        rd_word[STAT_OVERRUN]    = overrun_d;
      end
      REG_PERIOD:   rd_word = period_q;
      REG_MCYC_LO:  rd_word = mcyc_d[31:0];
      REG_MCYC_HI:  rd_word = 32'(mcyc_d[32 +: HI_W]);
      REG_MINST_LO: rd_word = minst_d[31:0];
      REG_MINST_HI: rd_word = 32'(minst_d[32 +: HI_W]);
      REG_STALL_LO: rd_word = stall_d[31:0];
      REG_STALL_HI: rd_word = 32'(stall_d[32 +: HI_W]);
      default:      rd_word = '0;
    endcase
  end

  // Control/status registers, shadows and interrupt
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      auto_q       <= 1'b0;
      per_en_q     <= 1'b0;
      irq_en_q     <= 1'b0;
      snap_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
      period_q     <= 32'd0;
      mcyc_q       <= '0;
      minst_q      <= '0;
      stall_q      <= '0;
      irq          <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        auto_q   <= req_wdata[CTRL_AUTO];
        per_en_q <= req_wdata[CTRL_PER_EN];
        irq_en_q <= req_wdata[CTRL_IRQ_EN];
      end
      if (wr_period) period_q <= req_wdata;
      snap_valid_q <= snap_valid_d;
      overrun_q    <= overrun_d;
      mcyc_q       <= mcyc_d;
      minst_q      <= minst_d;
      stall_q      <= stall_d;
      irq          <= irq_en_q && snap_valid_q;
    end
  end

  // Bus handshake FSM with registered response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RD_IDLE;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        RD_IDLE: begin
          req_ready <= 1'b1;
          if (accept) begin
            state     <= RD_RESP;
            req_ready <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_rdata <= (req_we || err) ? 32'd0 : rd_word;
            rsp_err   <= err;
          end
        end
        RD_RESP: begin
          if (rsp_ready) begin
            state     <= RD_IDLE;
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_telemetry_snapshot_reader.sv
// Scoreboard bench for telemetry_snapshot_reader: a per-edge behavioural model predicts each
// response into a queue; a monitor compares DUT outputs against it every cycle.
module tb_telemetry_snapshot_reader;

  localparam int unsigned WIDTH  = 64;
  localparam int unsigned ADDR_W = 8;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [WIDTH-1:0]  mcycle, minstret, stall_cycles;
  logic              req_valid, req_ready, req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid, rsp_ready, rsp_err, irq;
  logic [31:0]       rsp_rdata;

  telemetry_snapshot_reader #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .mcycle       (mcycle),
    .minstret     (minstret),
    .stall_cycles (stall_cycles),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_addr     (req_addr),
    .req_we       (req_we),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .irq          (irq)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  rsp_t        exp_q[$];
  logic [31:0] last_rdata;
  logic        last_err;
  bit          rand_cnt;

  logic [7:0] map_addrs [9] = '{8'h00, 8'h04, 8'h08, 8'h10, 8'h14, 8'h18, 8'h1C, 8'h20, 8'h24};
  logic [7:0] rnd_addrs [14] = '{8'h00, 8'h04, 8'h08, 8'h10, 8'h10, 8'h14, 8'h18, 8'h1C,
                                 8'h20, 8'h24, 8'h24, 8'h0C, 8'h30, 8'h06};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: register file semantics stepped once per clock edge
  logic        m_auto, m_per_en, m_irq_en, m_sv, m_ov, m_irq, m_ready, m_pend;
  logic [31:0] m_period, m_since;
  logic [63:0] m_sh [3];
  int unsigned m_acc_cnt = 0;
  int unsigned m_hs_cnt  = 0;

  task automatic model_step();
    bit          acc, hs, tick, err, wr, rd, cap, clr, restart;
    logic [31:0] rw;
    rsp_t        e;
    acc     = req_valid && m_ready;
    hs      = m_pend && rsp_ready;
    tick    = m_per_en && (m_period != 32'd0) && ((m_since % m_period) == (m_period - 32'd1));
    err     = !(req_addr inside {8'h00, 8'h04, 8'h08, 8'h10, 8'h14, 8'h18, 8'h1C, 8'h20, 8'h24});
    wr      = acc && req_we && !err;
    rd      = acc && !req_we && !err;
    cap     = tick || (wr && req_addr == 8'h00 && req_wdata[0]) || (rd && req_addr == 8'h10 && m_auto);
    clr     = (rd && req_addr == 8'h24) || (wr && req_addr == 8'h04 && req_wdata[0]);
    restart = !m_per_en || (m_period == 32'd0) || (wr && req_addr == 8'h08);
    m_irq   = m_irq_en && m_sv;
    if (tick && m_sv && !clr) m_ov = 1'b1;
    else if (wr && req_addr == 8'h04 && req_wdata[1]) m_ov = 1'b0;
    if (cap) m_sv = 1'b1;
    else if (clr) m_sv = 1'b0;
    if (cap) begin
      m_sh[0] = mcycle;
      m_sh[1] = minstret;
      m_sh[2] = stall_cycles;
    end
    if (wr && req_addr == 8'h00) begin
      m_auto   = req_wdata[1];
      m_per_en = req_wdata[2];
      m_irq_en = req_wdata[3];
    end
    if (wr && req_addr == 8'h08) m_period = req_wdata;
    m_since = restart ? 32'd0 : m_since + 32'd1;
    if (acc) begin
      rw = 32'd0;
      if (rd) begin
        case (req_addr)
          8'h00:   rw = {28'd0, m_irq_en, m_per_en, m_auto, 1'b0};
          8'h04:   rw = {30'd0, m_ov, m_sv};
          8'h08:   rw = m_period;
          8'h10:   rw = m_sh[0][31:0];
          8'h14:   rw = m_sh[0][63:32];
          8'h18:   rw = m_sh[1][31:0];
          8'h1C:   rw = m_sh[1][63:32];
          8'h20:   rw = m_sh[2][31:0];
          default: rw = m_sh[2][63:32];
        endcase
      end
      e.rdata = rw;
      e.err   = err;
      exp_q.push_back(e);
      m_acc_cnt++;
      m_ready = 1'b0;
      m_pend  = 1'b1;
    end else if (hs) begin
      m_pend  = 1'b0;
      m_ready = 1'b1;
      m_hs_cnt++;
    end else if (!m_pend) begin
      m_ready = 1'b1;
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_auto = 1'b0; m_per_en = 1'b0; m_irq_en = 1'b0; m_sv = 1'b0; m_ov = 1'b0;
      m_irq = 1'b0; m_ready = 1'b0; m_pend = 1'b0; m_period = 32'd0; m_since = 32'd0;
      m_sh[0] = 64'd0; m_sh[1] = 64'd0; m_sh[2] = 64'd0;
    end else begin
      model_step();
    end
  end

  // Monitor: handshake outputs every cycle, response payload against the queue head
  always @(negedge clk) begin
    #1;
    if (rst_n) begin
      check("req_ready", 64'(req_ready), 64'(m_ready));
      check("rsp_valid", 64'(rsp_valid), 64'(m_pend));
      check("irq", 64'(irq), 64'(m_irq));
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL rsp_unexpected: got rdata 0x%0h with no expected response", rsp_rdata);
        end else begin
          check("rsp_rdata", 64'(rsp_rdata), 64'(exp_q[0].rdata));
          check("rsp_err", 64'(rsp_err), 64'(exp_q[0].err));
          if (rsp_ready) begin
            last_rdata = rsp_rdata;
            last_err   = rsp_err;
            void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
    if (rand_cnt) begin
      mcycle       = {$urandom, $urandom};
      minstret     = {$urandom, $urandom};
      stall_cycles = {$urandom, $urandom};
    end
  endtask

  task automatic wait_acc(input int unsigned base);
    int t = 0;
    while (m_acc_cnt == base && t < 40) begin step(); t++; end
    check("accept_timeout", 64'(m_acc_cnt != base), 64'd1);
  endtask

  task automatic wait_hs(input int unsigned base);
    int t = 0;
    while (m_hs_cnt == base && t < 40) begin step(); t++; end
    check("response_timeout", 64'(m_hs_cnt != base), 64'd1);
  endtask

  task automatic bus(input logic [7:0] a, input bit we, input logic [31:0] wd, input int unsigned bp);
    int unsigned b;
    step();
    req_valid = 1'b1; req_addr = a; req_we = we; req_wdata = wd;
    b = m_acc_cnt;
    wait_acc(b);
    req_valid = 1'b0;
    repeat (bp) step();
    rsp_ready = 1'b1;
    b = m_hs_cnt;
    wait_hs(b);
    rsp_ready = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
    #20;
    exp_q.delete();
    @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned b;
    logic [7:0]  a;
    logic [31:0] wd;
    req_valid = 1'b0; req_addr = '0; req_we = 1'b0; req_wdata = '0; rsp_ready = 1'b0;
    mcycle = '0; minstret = '0; stall_cycles = '0; rand_cnt = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    step();
    check("reset_irq", 64'(irq), 64'd0);
    check("reset_req_ready", 64'(req_ready), 64'd1);
    foreach (map_addrs[i]) bus(map_addrs[i], 1'b0, 32'd0, 0);

    // Coherent snapshot across a lo->hi carry
    mcycle = 64'h0000_0001_FFFF_FFFF;
    bus(8'h00, 1'b1, 32'h1, 0);
    mcycle = 64'h0000_0002_0000_0000;
    bus(8'h10, 1'b0, 32'd0, 0);
    check("coherent_lo", 64'(last_rdata), 64'hFFFF_FFFF);
    bus(8'h14, 1'b0, 32'd0, 0);
    check("coherent_hi", 64'(last_rdata), 64'h1);

    // AUTO capture on lo read, then consume
    bus(8'h04, 1'b1, 32'h3, 0);
    bus(8'h00, 1'b1, 32'h2, 0);
    minstret = 64'd42;
    bus(8'h18, 1'b0, 32'd0, 0);
    check("auto_minst_before", 64'(last_rdata), 64'd0);
    bus(8'h10, 1'b0, 32'd0, 0);
    check("auto_mcyc_lo", 64'(last_rdata), 64'd0);
    bus(8'h04, 1'b0, 32'd0, 0);
    check("auto_status", 64'(last_rdata), 64'h1);
    bus(8'h24, 1'b0, 32'd0, 0);
    bus(8'h04, 1'b0, 32'd0, 0);
    check("consume_status", 64'(last_rdata), 64'h0);

    // Periodic capture and overrun
    bus(8'h08, 1'b1, 32'd4, 0);
    bus(8'h00, 1'b1, 32'hC, 0);
    repeat (12) step();
    bus(8'h04, 1'b0, 32'd0, 0);
    check("overrun_status", 64'(last_rdata), 64'h3);
    bus(8'h04, 1'b1, 32'h3, 0);
    bus(8'h04, 1'b0, 32'd0, 1);
    bus(8'h00, 1'b1, 32'h0, 0);

    // Backpressure with the next request already waiting
    bus(8'h08, 1'b1, 32'h1234, 0);
    step();
    req_valid = 1'b1; req_addr = 8'h08; req_we = 1'b0;
    b = m_acc_cnt;
    wait_acc(b);
    req_addr = 8'h04;
    b = m_acc_cnt;
    repeat (5) begin
      check("bp_rsp_valid", 64'(rsp_valid), 64'd1);
      check("bp_rdata", 64'(rsp_rdata), 64'h1234);
      check("bp_req_ready", 64'(req_ready), 64'd0);
      step();
    end
    rsp_ready = 1'b1;
    wait_hs(m_hs_cnt);
    rsp_ready = 1'b0;
    check("bp_no_early_accept", 64'(m_acc_cnt - b), 64'd0);
    wait_acc(b);
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    wait_hs(m_hs_cnt);
    rsp_ready = 1'b0;

    // Errors and read-only writes
    bus(8'h30, 1'b0, 32'd0, 0);
    check("err_0x30", 64'(last_err), 64'd1);
    bus(8'h02, 1'b0, 32'd0, 0);
    check("err_0x02", 64'(last_err), 64'd1);
    bus(8'h0C, 1'b1, 32'hFF, 0);
    bus(8'h44, 1'b0, 32'd0, 0);
    bus(8'h14, 1'b1, 32'hDEAD, 0);
    check("ro_write_err", 64'(last_err), 64'd0);

    // Reset while a response is pending
    step();
    req_valid = 1'b1; req_addr = 8'h08; req_we = 1'b0;
    wait_acc(m_acc_cnt);
    req_valid = 1'b0;
    step();
    check("pre_reset_rsp_valid", 64'(rsp_valid), 64'd1);
    do_reset();
    step();
    check("post_reset_rsp_valid", 64'(rsp_valid), 64'd0);
    check("post_reset_req_ready", 64'(req_ready), 64'd1);
    bus(8'h08, 1'b0, 32'd0, 0);
    check("post_reset_period", 64'(last_rdata), 64'd0);

    // Randomized traffic
    rand_cnt = 1'b1;
    repeat (250) begin
      a  = rnd_addrs[$urandom_range(0, 13)];
      wd = $urandom;
      if (a == 8'h08) wd = 32'($urandom_range(0, 6));
      if (a == 8'h00) wd = 32'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) step();
      bus(a, 1'($urandom_range(0, 1)), wd, $urandom_range(0, 3));
    end
    rand_cnt = 1'b0;
    repeat (3) step();
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
